cam_axis_frame_buffer: RTL and testbench

// Elastic AXI-Stream frame buffer between the camera DMA packer output and the S2MM DMA slave port.

---
 rtl/cam_axis_frame_buffer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_cam_axis_frame_buffer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_axis_frame_buffer.sv
// ---------------------------------------------------------------------------
// cam_axis_frame_buffer
//
// Elastic AXI-Stream frame buffer between the camera DMA packer and the S2MM
// DMA slave port. Soaks up S2MM back-pressure bursts so the packer does not
// stall the pixel path mid-line. It also guarantees that every frame handed
// downstream ends with tlast. If a frame stalls on the input for
// stall_timeout cycles, the block injects an empty terminating beat. It then
// drops the rest of that frame until software issues frame_start.
//
// Ports
//   sys_clk, sys_rst    clock, asynchronous active-high reset
//   frame_start         1-cycle pulse: clears counters/flags, leaves DISCARD
//   stall_timeout       max idle cycles inside a frame (0 disables abort)
//   s_t*                upstream AXI-Stream slave (data/keep/last/valid/ready)
//   m_t*                downstream AXI-Stream master towards S2MM
//   level               beats held (RAM + output register)
//   beat_cnt            beats accepted since frame_start (dropped excluded)
//   frame_cnt           frames closed since frame_start (normal + aborted)
//   aborted, overflow   sticky status flags, cleared by frame_start
//
// Storage is a RAM array plus a registered output stage. A beat written while
// the RAM is empty and the output stage is free goes straight into the output
// register. This gives a one-cycle input-to-output latency.
// ---------------------------------------------------------------------------
module cam_axis_frame_buffer #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int DEPTH  = 512
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   frame_start,
    input  logic [31:0]            stall_timeout,
    input  logic [DATA_W-1:0]      s_tdata,
    input  logic [KEEP_W-1:0]      s_tkeep,
    input  logic                   s_tlast,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic [KEEP_W-1:0]      m_tkeep,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [$clog2(DEPTH):0] level,
    output logic [31:0]            beat_cnt,
    output logic [15:0]            frame_cnt,
    output logic                   aborted,
    output logic                   overflow
);

    localparam int AW     = $clog2(DEPTH);
    localparam int WORD_W = DATA_W + KEEP_W + 1;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_ABORT,
        ST_DISCARD
    } state_t;

    state_t state_reg, state_next;

    // Storage word layout: {last, keep, data}
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] out_word_reg;
    logic [WORD_W-1:0] wr_word;
    logic              out_valid_reg;
    logic [AW:0]       ram_cnt_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     wr_ptr_reg;

    logic [31:0] idle_cnt_reg;
    logic [31:0] idle_inc;
    logic [31:0] beat_cnt_reg, beat_base;
    logic [15:0] frame_cnt_reg, frame_base;
    logic        aborted_reg;
    logic        overflow_reg;

    logic has_space;
    logic push_in;
    logic push_abort;
    logic wr_en;
    logic pop;
    logic out_free;
    logic ram_rd;
    logic bypass;
    logic ram_wr;
    logic timeout_hit;
    logic frame_close;
    logic stall_seen;

    // ------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------
    assign level     = ram_cnt_reg + {{AW{1'b0}}, out_valid_reg};
    assign has_space = (level < DEPTH_L);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    assign idle_inc    = idle_cnt_reg + 32'd1;
    assign timeout_hit = (stall_timeout != 32'd0) && (idle_inc >= stall_timeout);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (push_in && !s_tlast) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (push_in) begin
                    if (s_tlast) begin
                        state_next = ST_IDLE;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (push_abort) begin
                    state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (frame_start) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. s_tready is forced low while reset is held, so
    // upstream sees no ready during reset.
    // ------------------------------------------------------------------
    always_comb begin
        s_tready   = 1'b0;
        push_in    = 1'b0;
        push_abort = 1'b0;
        if (!sys_rst) begin
            case (state_reg)
                ST_IDLE, ST_STREAM: begin
                    s_tready = has_space;
                    push_in  = s_tvalid & has_space;
                end
                ST_ABORT: begin
                    push_abort = has_space;
                end
                ST_DISCARD: begin
                    s_tready = 1'b1;
                end
                default: begin
                    s_tready = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Mid-frame idle counter. It runs only in STREAM. Any cycle without
    // an accepted beat counts, including cycles lost to back-pressure.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            idle_cnt_reg <= '0;
        end else if (state_reg == ST_STREAM && !push_in) begin
            idle_cnt_reg <= idle_inc;
        end else begin
            idle_cnt_reg <= '0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO datapath
    // ------------------------------------------------------------------
    assign wr_en   = push_in | push_abort;
    assign wr_word = push_abort ? {1'b1, {KEEP_W{1'b0}}, {DATA_W{1'b0}}}
                                : {s_tlast, s_tkeep, s_tdata};

    assign pop      = out_valid_reg & m_tready;
    assign out_free = ~out_valid_reg | pop;
    // The RAM is non-empty only while the output register is occupied.
    // When the RAM is empty, a new write can bypass straight to the output.
    assign ram_rd   = out_free & (ram_cnt_reg != '0);
    assign bypass   = out_free & (ram_cnt_reg == '0) & wr_en;
    assign ram_wr   = wr_en & ~bypass;

    always_ff @(posedge sys_clk) begin
        if (ram_wr) begin
            mem[wr_ptr_reg] <= wr_word;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_word_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else if (ram_rd) begin
            out_word_reg  <= mem[rd_ptr_reg];
            out_valid_reg <= 1'b1;
        end else if (bypass) begin
            out_word_reg  <= wr_word;
            out_valid_reg <= 1'b1;
        end else if (pop) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            ram_cnt_reg <= '0;
        end else begin
            if (ram_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (ram_rd) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            ram_cnt_reg <= ram_cnt_reg + (AW + 1)'(ram_wr) - (AW + 1)'(ram_rd);
        end
    end

    assign m_tdata  = out_word_reg[DATA_W-1:0];
    assign m_tkeep  = out_word_reg[DATA_W +: KEEP_W];
    assign m_tlast  = out_word_reg[WORD_W-1];
    assign m_tvalid = out_valid_reg;

    // ------------------------------------------------------------------
    // Status counters. frame_start clears them first. An event in the
    // same cycle is then applied on top of the cleared value.
    // ------------------------------------------------------------------
    assign frame_close = (push_in & s_tlast) | push_abort;
    assign stall_seen  = (state_reg == ST_STREAM) & s_tvalid & ~s_tready;
    assign beat_base   = frame_start ? 32'd0 : beat_cnt_reg;
    assign frame_base  = frame_start ? 16'd0 : frame_cnt_reg;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            beat_cnt_reg  <= '0;
            frame_cnt_reg <= '0;
            aborted_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            beat_cnt_reg  <= beat_base + 32'(push_in);
            frame_cnt_reg <= frame_base + 16'(frame_close);
            aborted_reg   <= (~frame_start & aborted_reg) | push_abort;
            overflow_reg  <= (~frame_start & overflow_reg) | stall_seen;
        end
    end

    assign beat_cnt  = beat_cnt_reg;
    assign frame_cnt = frame_cnt_reg;
    assign aborted   = aborted_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_cam_axis_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_cam_axis_frame_buffer
//
// Directed bench for cam_axis_frame_buffer (DEPTH=8). A queue-based
// behavioural model predicts ready, the output beat, level and the status
// counters. These predictions are compared on every falling edge. Literal
// expectations after each scenario pin the model itself.
// ---------------------------------------------------------------------------
module tb_cam_axis_frame_buffer;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int DEPTH  = 8;

    logic        sys_clk       = 1'b0;
    logic        sys_rst       = 1'b1;
    logic        frame_start   = 1'b0;
    logic [31:0] stall_timeout = 32'd0;
    logic [63:0] s_tdata       = '0;
    logic [7:0]  s_tkeep       = '0;
    logic        s_tlast       = 1'b0;
    logic        s_tvalid      = 1'b0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready      = 1'b0;
    logic [3:0]  level;
    logic [31:0] beat_cnt;
    logic [15:0] frame_cnt;
    logic        aborted;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    cam_axis_frame_buffer #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W),
        .DEPTH  (DEPTH)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .frame_start   (frame_start),
        .stall_timeout (stall_timeout),
        .s_tdata       (s_tdata),
        .s_tkeep       (s_tkeep),
        .s_tlast       (s_tlast),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .m_tdata       (m_tdata),
        .m_tkeep       (m_tkeep),
        .m_tlast       (m_tlast),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .level         (level),
        .beat_cnt      (beat_cnt),
        .frame_cnt     (frame_cnt),
        .aborted       (aborted),
        .overflow      (overflow)
    );

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] bdata(input int f, input int i);
        return {f[31:0], i[31:0]};
    endfunction

    function automatic logic [7:0] kpat(input int i);
        return 8'((i * 37) + 1);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: the buffer is a queue of beats. A beat stored
    // before this cycle is visible on the output.
    // ------------------------------------------------------------------
    typedef enum {M_IDLE, M_STREAM, M_ABORT, M_DISCARD} mode_t;

    mode_t        m_mode     = M_IDLE;
    logic [72:0]  m_q[$];
    int unsigned  m_idle     = 0;
    logic [31:0]  m_beats    = '0;
    logic [15:0]  m_frames   = '0;
    logic         m_aborted  = 1'b0;
    logic         m_overflow = 1'b0;

    function automatic logic model_ready();
        if (sys_rst) return 1'b0;
        if (m_mode == M_IDLE || m_mode == M_STREAM) return (m_q.size() < DEPTH);
        if (m_mode == M_DISCARD) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge sys_clk) begin : model_update
        logic rdy;
        logic acc;
        logic space;
        if (sys_rst) begin
            m_mode     = M_IDLE;
            m_q.delete();
            m_idle     = 0;
            m_beats    = '0;
            m_frames   = '0;
            m_aborted  = 1'b0;
            m_overflow = 1'b0;
        end else begin
            rdy   = model_ready();
            acc   = s_tvalid && rdy;
            space = (m_q.size() < DEPTH);
            if (frame_start) begin
                m_beats    = '0;
                m_frames   = '0;
                m_aborted  = 1'b0;
                m_overflow = 1'b0;
            end
            if (m_q.size() != 0 && m_tready) void'(m_q.pop_front());
            case (m_mode)
                M_IDLE, M_STREAM: begin
                    if (acc) begin
                        m_q.push_back({s_tlast, s_tkeep, s_tdata});
                        m_beats++;
                        m_idle = 0;
                        if (s_tlast) begin
                            m_frames++;
                            m_mode = M_IDLE;
                        end else begin
                            m_mode = M_STREAM;
                        end
                    end else if (m_mode == M_STREAM) begin
                        if (s_tvalid) m_overflow = 1'b1;
                        m_idle++;
                        if (stall_timeout != 0 && m_idle >= stall_timeout) m_mode = M_ABORT;
                    end
                end
                M_ABORT: begin
                    if (space) begin
                        m_q.push_back({1'b1, 8'h00, 64'h0});
                        m_aborted = 1'b1;
                        m_frames++;
                        m_mode = M_DISCARD;
                    end
                end
                M_DISCARD: begin
                    if (frame_start) m_mode = M_IDLE;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            check("rst_s_tready", s_tready, 0);
            check("rst_m_tvalid", m_tvalid, 0);
            check("rst_m_beat", {m_tlast, m_tkeep, m_tdata}, 0);
            check("rst_level", level, 0);
            check("rst_counters", {beat_cnt, frame_cnt, aborted, overflow}, 0);
        end else begin
            check("s_tready", s_tready, model_ready());
            check("m_tvalid", m_tvalid, m_q.size() != 0);
            if (m_q.size() != 0) check("m_beat", {m_tlast, m_tkeep, m_tdata}, m_q[0]);
            check("level", level, m_q.size());
            check("beat_cnt", beat_cnt, m_beats);
            check("frame_cnt", frame_cnt, m_frames);
            check("aborted", aborted, m_aborted);
            check("overflow", overflow, m_overflow);
        end
    end

    // Output-side observation for the literal end-of-scenario checks
    int          rx_count = 0;
    logic [72:0] last_rx  = '0;

    always @(posedge sys_clk) begin
        if (!sys_rst && m_tvalid && m_tready) begin
            rx_count++;
            last_rx = {m_tlast, m_tkeep, m_tdata};
        end
    end

    // Optional background m_tready pattern
    logic rdy_toggle = 1'b0;
    int   tog_cyc    = 0;

    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            tog_cyc++;
            if (rdy_toggle) m_tready = (tog_cyc % 3) != 0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge+1)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        int waited = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge sys_clk);
        while (!s_tready && waited < 3000) begin
            waited++;
            @(negedge sys_clk);
        end
        check("send_accept", s_tready, 1);
        @(posedge sys_clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rx0;
        sys_rst = 1'b1;
        tick(3);
        check("reset_s_tready", s_tready, 0);
        check("reset_level", level, 0);
        sys_rst       = 1'b0;
        m_tready      = 1'b1;
        stall_timeout = 32'd0;
        tick(1);
        check("idle_s_tready", s_tready, 1);

        // 1: 100-beat frame, sink always ready
        rx0 = rx_count;
        for (int i = 1; i <= 100; i++) begin
            send(bdata(1, i), kpat(i), i == 100);
            if (i == 1) check("t1_first_out_latency", m_tvalid, 1);
        end
        tick(5);
        check("t1_beat_cnt", beat_cnt, 100);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_rx_count", rx_count - rx0, 100);
        check("t1_last_beat", last_rx, {1'b1, kpat(100), bdata(1, 100)});

        // 2: sink stalled while the buffer fills, then released
        m_tready = 1'b0;
        rx0 = rx_count;
        for (int i = 1; i <= 8; i++) send(bdata(2, i), 8'hFF, 1'b0);
        check("t2_full_ready", s_tready, 0);
        check("t2_full_level", level, 8);
        s_tdata  = bdata(2, 9);
        s_tkeep  = 8'hFF;
        s_tvalid = 1'b1;
        tick(3);
        check("t2_overflow", overflow, 1);
        m_tready = 1'b1;
        send(bdata(2, 9), 8'hFF, 1'b0);
        send(bdata(2, 10), 8'hFF, 1'b1);
        tick(12);
        check("t2_rx_count", rx_count - rx0, 10);
        check("t2_beat_cnt", beat_cnt, 110);
        check("t2_frame_cnt", frame_cnt, 2);

        // 3: stall timeout of 16; a 15-cycle gap survives, 16 aborts
        pulse_fs();
        stall_timeout = 32'd16;
        rx0 = rx_count;
        for (int i = 1; i <= 4; i++) send(bdata(3, i), 8'hFF, 1'b0);
        tick(15);
        send(bdata(3, 5), 8'hFF, 1'b0);
        tick(16);
        tick(4);
        check("t3_aborted", aborted, 1);
        check("t3_frame_cnt", frame_cnt, 1);
        check("t3_beat_cnt", beat_cnt, 5);
        check("t3_rx_count", rx_count - rx0, 6);
        check("t3_abort_beat", last_rx, {1'b1, 8'h00, 64'h0});
        for (int i = 1; i <= 3; i++) send(bdata(3, 10 + i), 8'hFF, i == 2);
        tick(4);
        check("t3_discard_frames", frame_cnt, 1);
        check("t3_discard_beats", beat_cnt, 5);
        check("t3_discard_rx", rx_count - rx0, 6);
        pulse_fs();
        check("t3_fs_frame_cnt", frame_cnt, 0);
        check("t3_fs_aborted", aborted, 0);

        // 4: timeout disabled, long mid-frame gap, toggling sink
        stall_timeout = 32'd0;
        rdy_toggle = 1'b1;
        rx0 = rx_count;
        send(bdata(4, 1), kpat(1), 1'b0);
        send(bdata(4, 2), kpat(2), 1'b0);
        tick(1000);
        for (int i = 3; i <= 6; i++) send(bdata(4, i), kpat(i), i == 6);
        tick(20);
        rdy_toggle = 1'b0;
        m_tready = 1'b1;
        tick(3);
        check("t4_aborted", aborted, 0);
        check("t4_frame_cnt", frame_cnt, 1);
        check("t4_beat_cnt", beat_cnt, 6);
        check("t4_rx_count", rx_count - rx0, 6);

        // 5: frame_start coincident with the first beat of the next frame
        frame_start = 1'b1;
        send(bdata(5, 1), 8'h0F, 1'b0);
        frame_start = 1'b0;
        check("t5_beat_cnt", beat_cnt, 1);
        check("t5_frame_cnt", frame_cnt, 0);
        check("t5_aborted", aborted, 0);
        send(bdata(5, 2), 8'hFF, 1'b1);
        tick(3);
        check("t5_frame_done", frame_cnt, 1);

        // 6: reset mid-frame with five beats held
        m_tready = 1'b0;
        for (int i = 1; i <= 5; i++) send(bdata(6, i), 8'hFF, 1'b0);
        check("t6_level_before", level, 5);
        sys_rst = 1'b1;
        tick(2);
        check("t6_rst_m_tvalid", m_tvalid, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_s_tready", s_tready, 0);
        sys_rst = 1'b0;
        m_tready = 1'b1;
        tick(1);
        check("t6_post_s_tready", s_tready, 1);
        check("t6_post_level", level, 0);
        stall_timeout = 32'd4;
        tick(10);
        check("t6_idle_no_abort", aborted, 0);
        send(bdata(7, 1), 8'hFF, 1'b1);
        tick(3);
        check("t6_single_beat_frame", frame_cnt, 1);
        check("t6_single_beat_cnt", beat_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
